// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage: jump opcodes, the fetch
// FSM state type, the default reset PC and a small opcode decode helper.
// No ports (package).
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    // BOOT spends one cycle after reset release before fetching starts.
    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

    // True for the direct jumps that fetch resolves on its own (j / jal).
    function automatic logic is_direct_jump(input logic [31:0] instr);
        return (instr[31:26] == OP_J) || (instr[31:26] == OP_JAL);
    endfunction

endpackage

// File: rtl/fetch_unit_pc_register.sv
// -----------------------------------------------------------------------------
// pc_register
// Program counter storage for the fetch stage.
//   clk      : clock, rising edge
//   reset    : asynchronous active-high reset, loads RESET_PC
//   load     : when high, next_pc is captured on the rising edge
//   next_pc  : value to load
//   pc       : current program counter
// -----------------------------------------------------------------------------
module pc_register
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] next_pc,
    output logic [31:0] pc
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: owns the PC, resolves j/jal locally, accepts
// redirects from later stages and fills the IF/ID pipeline register.
//   clk             : clock, rising edge
//   reset           : asynchronous active-high reset
//   stall           : hold PC and IF/ID
//   redirect_valid  : later-stage taken branch / jr this cycle
//   redirect_target : redirect destination
//   pc_out          : current PC, instruction memory address
//   instr_in        : instruction returned (combinationally) for pc_out
//   ifid_instr      : registered instruction for decode
//   ifid_pc4        : registered PC+4 of that instruction (jal link value)
//   ifid_valid      : IF/ID holds a real instruction
//   align_err       : one-cycle pulse on a misaligned redirect
// Optional feature: define FETCH_ALIGN_CHECK_EN to clear the low two bits of
// redirect targets and flag misaligned ones on align_err. Without it the
// target is loaded unmodified and align_err is tied low.
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc_out,
    input  logic [31:0] instr_in,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        align_err
);

    fetch_state_t state_q, state_d;

    logic        pc_load;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] redirect_pc;
    logic        ifid_capture;
    logic        ifid_flush;

    // Wraps naturally at 2^32 because the sum is kept to 32 bits.
    assign pc_plus4    = pc_out + 32'd4;
    assign jump_target = {pc_plus4[31:28], instr_in[25:0], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_pc = {redirect_target[31:2], 2'b00};
`else
    assign redirect_pc = redirect_target;
`endif

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk     (clk),
        .reset   (reset),
        .load    (pc_load),
        .next_pc (pc_next),
        .pc      (pc_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        pc_load      = 1'b0;
        pc_next      = pc_out;
        ifid_capture = 1'b0;
        ifid_flush   = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                state_d    = ST_RUN;
                ifid_flush = 1'b1;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    // A redirect wins even over stall: the fetched path is wrong.
                    pc_load    = 1'b1;
                    pc_next    = redirect_pc;
                    ifid_flush = 1'b1;
                end else if (!stall) begin
                    pc_load      = 1'b1;
                    ifid_capture = 1'b1;
                    // No delay slot: a j/jal goes straight to its target.
                    pc_next      = is_direct_jump(instr_in) ? jump_target : pc_plus4;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_instr <= '0;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
        end else if (ifid_flush) begin
            ifid_valid <= 1'b0;
        end else if (ifid_capture) begin
            ifid_instr <= instr_in;
            ifid_pc4   <= pc_plus4;
            ifid_valid <= 1'b1;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic align_set;

    assign align_set = (state_q == ST_RUN) && redirect_valid && (redirect_target[1:0] != 2'b00);

    // Registered so the flag lines up with the cycle the aligned target appears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            align_err <= 1'b0;
        end else begin
            align_err <= align_set;
        end
    end
`else
    assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. A reference model of the fetch rules
// predicts the post-edge state; predictions go into a queue and a monitor on
// the falling edge compares them with the DUT outputs.
// Honors FETCH_ALIGN_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        align_err;

    logic [31:0] imem [256];

    always #5 clk = ~clk;

    assign instr_in = imem[pc_out[9:2]];

    fetch_unit #(
        .RESET_PC (TB_RESET_PC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc_out          (pc_out),
        .instr_in        (instr_in),
        .ifid_instr      (ifid_instr),
        .ifid_pc4        (ifid_pc4),
        .ifid_valid      (ifid_valid),
        .align_err       (align_err)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        aerr;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_aerr;
    logic        m_boot;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = TB_RESET_PC;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_aerr  = 1'b0;
        m_boot  = 1'b1;
    endtask

    // One rising edge of the fetch rules, with the inputs that were present.
    task automatic model_step(input logic st, input logic rv, input logic [31:0] rt);
        logic [31:0] ins;
        logic [31:0] nxt4;
        ins    = imem[m_pc[9:2]];
        nxt4   = m_pc + 32'd4;
        m_aerr = 1'b0;
        if (m_boot) begin
            m_boot  = 1'b0;
            m_valid = 1'b0;
        end else if (rv) begin
            m_valid = 1'b0;
            if (ALIGN_EN) begin
                m_aerr = (rt % 4) != 0;
                m_pc   = rt - (rt % 4);
            end else begin
                m_pc = rt;
            end
        end else if (!st) begin
            m_instr = ins;
            m_pc4   = nxt4;
            m_valid = 1'b1;
            if (ins[31:26] == 6'd2 || ins[31:26] == 6'd3) begin
                m_pc = (nxt4 & 32'hF000_0000) | ({6'd0, ins[25:0]} * 4);
            end else begin
                m_pc = nxt4;
            end
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.pc    = m_pc;
        e.instr = m_instr;
        e.pc4   = m_pc4;
        e.valid = m_valid;
        e.aerr  = m_aerr;
        q.push_back(e);
    endtask

    // Apply inputs for one edge, advance the model, queue the prediction.
    task automatic drive(input logic st, input logic rv, input logic [31:0] rt);
        stall           = st;
        redirect_valid  = rv;
        redirect_target = rt;
        @(posedge clk);
        #1;
        if (reset) begin
            model_reset();
        end else begin
            model_step(st, rv, rt);
        end
        push_expected();
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"},         pc_out,            TB_RESET_PC);
        check({tag, "_ifid_instr"}, ifid_instr,        32'h0);
        check({tag, "_ifid_pc4"},   ifid_pc4,          32'h0);
        check({tag, "_ifid_valid"}, {31'd0, ifid_valid}, 32'h0);
        check({tag, "_align_err"},  {31'd0, align_err},  32'h0);
    endtask

    // Monitor: compares whenever a prediction is pending.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            check("pc_out",     pc_out,              mon_e.pc);
            check("ifid_valid", {31'd0, ifid_valid}, {31'd0, mon_e.valid});
            check("align_err",  {31'd0, align_err},  {31'd0, mon_e.aerr});
            if (mon_e.valid) begin
                check("ifid_instr", ifid_instr, mon_e.instr);
                check("ifid_pc4",   ifid_pc4,   mon_e.pc4);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
        imem[9] = 32'h0C00_000D;   // jal at 36 -> 52

        reset           = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        model_reset();
        #1;
        check_reset_values("por");

        @(posedge clk);
        #1;
        reset = 1'b0;
        check("boot_pc", pc_out, TB_RESET_PC);

        // BOOT, then 4, 8, 12, 16.
        repeat (5) drive(1'b0, 1'b0, 32'h0);
        // Stall at 16 for three cycles, then advance to 20.
        repeat (3) drive(1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        // 24, 28, 32, 36, then the jal at 36 goes to 52.
        repeat (5) drive(1'b0, 1'b0, 32'h0);
        // Redirect under stall flushes and loads 92.
        drive(1'b1, 1'b1, 32'd92);
        drive(1'b0, 1'b0, 32'h0);
        // Misaligned redirect.
        drive(1'b0, 1'b1, 32'h0000_0062);
        drive(1'b0, 1'b0, 32'h0);
        // Wrap from the top of the address space.
        drive(1'b0, 1'b1, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0);

        // Random program with occasional jumps, stalls and redirects.
        for (int i = 0; i < 256; i++) begin
            imem[i] = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                imem[i][31:26] = ($urandom_range(0, 1) == 0) ? 6'b000010 : 6'b000011;
            end
        end
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom);
        end

        // Asynchronous reset mid-cycle with a redirect pending.
        @(negedge clk);
        #2;
        reset           = 1'b1;
        stall           = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0100;
        #1;
        check_reset_values("async");
        model_reset();
        drive(1'b0, 1'b1, 32'h0000_0100);
        reset = 1'b0;
        repeat (6) drive(1'b0, 1'b0, 32'h0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port stall, input, 1, holds PC and IF/ID register.
REQ-005 SHALL have port redirect_valid, input, 1, later-stage taken branch or jr this cycle.
REQ-006 SHALL have port redirect_target, input, 32, redirect destination address.
REQ-007 SHALL have port pc_out, output, 32, current PC driven to instruction memory address.
REQ-008 SHALL have port instr_in, input, 32, combinational instruction returned for pc_out.
REQ-009 SHALL have port ifid_instr, output, 32, registered instruction for decode.
REQ-010 SHALL have port ifid_pc4, output, 32, registered PC+4 of that instruction (link value for jal).
REQ-011 SHALL have port ifid_valid, output, 1, IF/ID contents are a real instruction.
REQ-012 SHALL have port align_err, output, 1, misaligned redirect flag (see Configuration).

Function
REQ-013 SHALL hold a two-state FSM: BOOT, then RUN.
- BOOT lasts exactly one cycle after reset release.
- BOOT: PC not advanced, ifid_valid=0.
- RUN is held until reset.
REQ-014 SHALL select the next PC in RUN with this priority:
- redirect_valid -> redirect_target.
- stall -> hold.
- instr_in opcode 6'b000010 (j) or 6'b000011 (jal) -> {pc_out+4 [31:28], instr_in[25:0], 2'b00}.
- otherwise -> pc_out+4.
REQ-015 SHALL compute PC+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0.
REQ-016 SHALL, when not stalled and no redirect, capture instr_in and pc_out+4 into IF/ID with ifid_valid=1, including j/jal; no delay slot, so the instruction after a jump is never fetched.
REQ-017 SHALL, on redirect_valid, clear ifid_valid (flush) on the same edge the PC loads the target, regardless of stall.
REQ-018 SHALL, on stall without redirect, hold ifid_instr, ifid_pc4 and ifid_valid unchanged.
REQ-019 SHALL produce one-cycle latency from pc_out to ifid_* outputs.
REQ-020 SHALL treat instr_in=0 as an ordinary valid instruction (nop).

Reset
REQ-021 SHALL on reset assertion, immediately and without a clock:
- pc_out=RESET_PC.
- ifid_instr=0, ifid_pc4=0, ifid_valid=0.
- align_err=0.
- FSM=BOOT.
REQ-022 SHALL, on reset mid-operation, discard any pending redirect or jump.

Configuration
REQ-023 SHALL, with macro FETCH_ALIGN_CHECK_EN defined:
- pulse align_err for one cycle when redirect_valid is accepted with redirect_target[1:0]!=0.
- load the target with bits [1:0] cleared.
REQ-024 SHALL, without FETCH_ALIGN_CHECK_EN:
- tie align_err to 0.
- load redirect_target unmodified.

Structure
REQ-025 SHALL place in shared package fetch_pkg:
- opcode constants OP_J=6'b000010 and OP_JAL=6'b000011.
- the FSM state typedef.
- default RESET_PC constant.
REQ-026 SHALL instantiate one sub-module pc_register, holding the PC with async reset, load enable, and the registered next-PC value.

Verification
REQ-027 SHALL cover reset sequencing: reset pulse, then sequential instr_in -> pc_out 0 (BOOT), 0, 4, 8; ifid_pc4 4, 8 with ifid_valid=1 from first RUN capture.
REQ-028 SHALL cover jal at 36: pc_out=36, instr_in=32'h0C00_000D -> next pc_out=52, ifid_pc4=40, ifid_valid=1.
REQ-029 SHALL cover stall: stall=1 for 3 cycles at pc_out=16 -> pc_out and IF/ID unchanged for 3 cycles, then pc_out=20.
REQ-030 SHALL cover redirect under stall: stall=1 and redirect_valid=1, target 92 -> pc_out=92 and ifid_valid=0 next cycle.
REQ-031 SHALL cover a misaligned redirect to 32'h62:
- with FETCH_ALIGN_CHECK_EN: pc_out=32'h60 and align_err=1 for one cycle.
- without: pc_out=32'h62 and align_err=0.
REQ-032 SHALL cover wrap and async reset: pc_out=32'hFFFF_FFFC -> pc_out=0; reset asserted mid-cycle -> pc_out=RESET_PC before the next clk edge.
